// File: rtl/uart_tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   - arb_state_e : arbiter state encoding (ARB_IDLE / ARB_BUSY)
//   - MAX_N       : largest requester count supported by the helpers
//   - oh2idx      : one-hot to binary index conversion
// -----------------------------------------------------------------------------
package uart_tx_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int MAX_N = 8;

    // OR-reduction encoder: no priority chain, exact for one-hot inputs.
    function automatic logic [2:0] oh2idx(input logic [MAX_N-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req upward starting at ptr+1,
// wrapping modulo N, and returns the first set position as a one-hot vector
// (all zero when no request is set).
// Ports:
//   req    [N-1:0]  request vector
//   ptr    [PW-1:0] index of the last winner (search starts just above it)
//   onehot [N-1:0]  selected requester
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot
);

    logic          found_s;
    logic [PW-1:0] idx_s;

    // Rotating first-one search beginning just above the last winner.
    always_comb begin
        onehot  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= N; i++) begin
            idx_s = PW'((int'(ptr) + i) % N);
            if (!found_s && req[idx_s]) begin
                onehot[idx_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Shares the UART TX FIFO write port between N byte-stream requesters with
// message-granular round-robin arbitration. Once granted, a requester owns the
// FIFO until it sends a byte flagged last, or until it has been silent
// (req_valid low) for TIMEOUT busy cycles.
// Ports:
//   clk, reset_l        bus clock, asynchronous active-low reset
//   req_valid/req_data/req_last [N] / [8N] / [N]  requester byte streams
//   req_ready [N]       accept strobe (owner only, blocked while FIFO full)
//   tx_fifo_af/cf       FIFO almost-full / completely-full from the UART
//   tx_fifo_we/wr_data  FIFO write strobe and byte (data is 0 when no write)
//   grant [N]           one-hot owner, 0 when idle
//   busy                a message is in progress
//   timeout_pulse       one cycle, on the cycle the silent owner is dropped
// -----------------------------------------------------------------------------
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N           = 4,
    parameter int TIMEOUT     = 1024,
    parameter bit START_ON_AF = 1'b1
) (
    input  logic           clk,
    input  logic           reset_l,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    input  logic           tx_fifo_af,
    input  logic           tx_fifo_cf,
    output logic           tx_fifo_we,
    output logic [7:0]     tx_fifo_wr_data,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic           timeout_pulse
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_EXP = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  pick_s;
    logic [PW-1:0] gidx_s;
    logic          gvalid_s;
    logic          glast_s;
    logic [7:0]    gdata_s;
    logic          xfer_s;
    logic          expire_s;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .onehot (pick_s)
    );

    // View of the current owner's stream and the transfer/expiry conditions.
    always_comb begin
        gvalid_s = |(req_valid & grant_q);
        glast_s  = |(req_last & grant_q);
        gdata_s  = 8'h00;
        for (int i = 0; i < N; i++) begin
            gdata_s = gdata_s | (req_data[8*i +: 8] & {8{grant_q[i]}});
        end
        gidx_s   = PW'(oh2idx(MAX_N'(grant_q)));
        xfer_s   = (state_q == ARB_BUSY) && gvalid_s && !tx_fifo_cf;
        // A byte arriving on the expiry cycle wins because expiry needs valid low.
        expire_s = (TIMEOUT > 0) && (state_q == ARB_BUSY) && !gvalid_s && (cnt_q == CNT_EXP);
    end

    // State, grant, round-robin pointer and idle counter registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= PW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: arbitration in IDLE, release on last byte or timeout in BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if ((|req_valid) && (!START_ON_AF || !tx_fifo_af)) begin
                    state_d = ARB_BUSY;
                    grant_d = pick_s;
                    cnt_d   = '0;
                end else begin
                    grant_d = '0;
                end
            end
            ARB_BUSY: begin
                if (xfer_s) begin
                    cnt_d = '0;
                    if (glast_s) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        ptr_d   = gidx_s;
                    end else begin
                        grant_d = grant_q;
                    end
                end else if (expire_s) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_s;
                    cnt_d   = '0;
                end else if (!gvalid_s) begin
                    // Silent owner: count, saturating so it can never wrap.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    // Valid but FIFO full: backpressure does not count as idle.
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: zero-latency handshake towards the owner and the FIFO.
    always_comb begin
        req_ready       = '0;
        tx_fifo_we      = 1'b0;
        tx_fifo_wr_data = 8'h00;
        timeout_pulse   = 1'b0;
        if (state_q == ARB_BUSY) begin
            req_ready       = grant_q & {N{!tx_fifo_cf}};
            tx_fifo_we      = xfer_s;
            tx_fifo_wr_data = xfer_s ? gdata_s : 8'h00;
            timeout_pulse   = expire_s;
        end else begin
            req_ready = '0;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
// Self-checking bench for uart_tx_arb (N=4, TIMEOUT=16, START_ON_AF=1).
// Requesters are modelled as byte queues; a message-level ownership model
// predicts every output each cycle. Directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 8192;

    logic           clk;
    logic           reset_l;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_fifo_af;
    logic           tx_fifo_cf;
    logic           tx_fifo_we;
    logic [7:0]     tx_fifo_wr_data;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_pulse;

    uart_tx_arb #(
        .N           (N),
        .TIMEOUT     (TIMEOUT),
        .START_ON_AF (1'b1)
    ) dut (
        .clk             (clk),
        .reset_l         (reset_l),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .tx_fifo_af      (tx_fifo_af),
        .tx_fifo_cf      (tx_fifo_cf),
        .tx_fifo_we      (tx_fifo_we),
        .tx_fifo_wr_data (tx_fifo_wr_data),
        .grant           (grant),
        .busy            (busy),
        .timeout_pulse   (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // requester byte queues: {last, data}
    logic [8:0] src_mem [N][DEPTH];
    int rd_p [N];
    int wr_p [N];
    logic [N-1:0] en;

    // behavioural model: who owns the FIFO, last winner, silent cycles
    int m_owner;
    int m_ptr;
    int m_silent;
    int m_pops;

    // bookkeeping
    int n_chk, n_pass, cyc, dut_writes, to_cnt, last_to_cyc;
    int log_cyc [$];
    logic [7:0] log_dat [$];
    logic [N-1:0] log_gnt [$];
    logic [N-1:0] s_grant, s_ready;
    logic s_we, s_to, s_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        src_mem[i][wr_p[i]] = {l, d};
        wr_p[i]++;
    endtask

    task automatic push_msg(input int i, input int len, input logic [7:0] base);
        for (int k = 0; k < len; k++) begin
            push(i, base + 8'(k), (k == len - 1));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rd_p[i] < wr_p[i]) begin
                req_valid[i]       = en[i];
                req_data[8*i +: 8] = src_mem[i][rd_p[i]][7:0];
                req_last[i]        = src_mem[i][rd_p[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // One clock cycle: apply inputs, predict and compare all outputs, advance model.
    task automatic step();
        logic [N-1:0] e_grant, e_ready;
        logic e_busy, e_we, e_to, xfer, last, found;
        logic [7:0] e_data;
        int c;
        drive();
        #1;
        e_grant = '0; e_ready = '0; e_busy = 1'b0; e_we = 1'b0; e_to = 1'b0;
        e_data = 8'h00; xfer = 1'b0; last = 1'b0;
        if (reset_l && m_owner >= 0) begin
            e_busy = 1'b1;
            e_grant[m_owner] = 1'b1;
            if (!tx_fifo_cf) e_ready[m_owner] = 1'b1;
            xfer = req_valid[m_owner] && !tx_fifo_cf;
            if (xfer) begin
                e_we   = 1'b1;
                e_data = src_mem[m_owner][rd_p[m_owner]][7:0];
                last   = src_mem[m_owner][rd_p[m_owner]][8];
            end else if (!req_valid[m_owner] && (m_silent + 1 == TIMEOUT)) begin
                e_to = 1'b1;
            end
        end
        chk("grant", grant, e_grant);
        chk("busy", busy, e_busy);
        chk("req_ready", req_ready, e_ready);
        chk("tx_fifo_we", tx_fifo_we, e_we);
        chk("tx_fifo_wr_data", tx_fifo_wr_data, e_data);
        chk("timeout_pulse", timeout_pulse, e_to);
        s_grant = grant; s_ready = req_ready; s_we = tx_fifo_we; s_to = timeout_pulse; s_busy = busy;
        if (tx_fifo_we) begin
            dut_writes++;
            log_cyc.push_back(cyc);
            log_dat.push_back(tx_fifo_wr_data);
            log_gnt.push_back(grant);
        end
        if (timeout_pulse) begin
            to_cnt++;
            last_to_cyc = cyc;
        end
        if (!reset_l) begin
            m_owner = -1; m_ptr = N - 1; m_silent = 0;
        end else if (m_owner >= 0) begin
            if (xfer) begin
                rd_p[m_owner]++;
                m_pops++;
                m_silent = 0;
                if (last) begin
                    m_ptr = m_owner; m_owner = -1;
                end
            end else if (e_to) begin
                m_ptr = m_owner; m_owner = -1; m_silent = 0;
            end else if (!req_valid[m_owner]) begin
                m_silent++;
            end
        end else if (req_valid != '0 && !tx_fifo_af) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && req_valid[c]) begin
                    m_owner = c; found = 1'b1;
                end
            end
            m_silent = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_writes(input int n, input int budget);
        int k;
        k = 0;
        while (log_dat.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("wait_writes", log_dat.size(), n);
    endtask

    task automatic clear_log();
        log_cyc.delete(); log_dat.delete(); log_gnt.delete();
    endtask

    int stall [N];
    int we_sum, to_sum;
    logic [N-1:0] or_vec;

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; dut_writes = 0; to_cnt = 0; last_to_cyc = 0;
        m_owner = -1; m_ptr = N - 1; m_silent = 0; m_pops = 0;
        for (int i = 0; i < N; i++) begin rd_p[i] = 0; wr_p[i] = 0; stall[i] = 0; end
        en = '1; tx_fifo_af = 1'b0; tx_fifo_cf = 1'b0;
        reset_l = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        @(negedge clk);
        step();
        step();
        chk("rst_grant", s_grant, 4'b0000);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_we", s_we, 1'b0);
        reset_l = 1'b1;

        // 1: two 3-byte messages from req0 and req2, never interleaved
        clear_log();
        push_msg(0, 3, 8'hA0);
        push_msg(2, 3, 8'hC0);
        run_until_writes(6, 30);
        if (log_dat.size() == 6) begin
            chk("t1_b0", log_dat[0], 8'hA0); chk("t1_b2", log_dat[2], 8'hA2);
            chk("t1_b3", log_dat[3], 8'hC0); chk("t1_b5", log_dat[5], 8'hC2);
            chk("t1_gnt0", log_gnt[0], 4'b0001); chk("t1_gnt3", log_gnt[3], 4'b0100);
            chk("t1_gap", log_cyc[3] - log_cyc[2], 2);
        end

        // 2: all four requesters, 1-byte messages -> order 0,1,2,3,0,...
        reset_l = 1'b0; step(); reset_l = 1'b1;
        clear_log();
        for (int i = 0; i < N; i++) begin
            push_msg(i, 1, 8'h10 + 8'(i));
            push_msg(i, 1, 8'h20 + 8'(i));
        end
        run_until_writes(8, 40);
        if (log_dat.size() == 8) begin
            chk("t2_g0", log_gnt[0], 4'b0001); chk("t2_g1", log_gnt[1], 4'b0010);
            chk("t2_g2", log_gnt[2], 4'b0100); chk("t2_g3", log_gnt[3], 4'b1000);
            chk("t2_g4", log_gnt[4], 4'b0001);
            chk("t2_d3", log_dat[3], 8'h13); chk("t2_d4", log_dat[4], 8'h20);
            chk("t2_d7", log_dat[7], 8'h23);
        end

        // 3: FIFO full for 10 cycles in the middle of req1's message
        clear_log();
        push_msg(1, 6, 8'h50);
        run_until_writes(2, 20);
        tx_fifo_cf = 1'b1; we_sum = 0; to_sum = 0; or_vec = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            we_sum += int'(s_we); to_sum += int'(s_to); or_vec |= s_ready;
        end
        chk("t3_we_held", we_sum, 0); chk("t3_no_to", to_sum, 0); chk("t3_ready_held", or_vec, 4'b0000);
        tx_fifo_cf = 1'b0;
        step();
        chk("t3_resume_we", s_we, 1'b1); chk("t3_resume_gnt", s_grant, 4'b0010);
        run_until_writes(6, 20);

        // 4: req3 sends a byte without last then goes silent; req0 pending
        clear_log();
        push_msg(2, 1, 8'h70);
        run_until_writes(1, 20);
        push(3, 8'h3A, 1'b0);
        push(0, 8'h0B, 1'b1);
        to_cnt = 0;
        run_until_writes(3, 60);
        if (log_dat.size() == 3) begin
            chk("t4_gnt_req3", log_gnt[1], 4'b1000);
            chk("t4_to_count", to_cnt, 1);
            chk("t4_to_delay", last_to_cyc - log_cyc[1], TIMEOUT);
            chk("t4_gnt_req0", log_gnt[2], 4'b0001);
            chk("t4_regrant", log_cyc[2] - last_to_cyc, 2);
        end

        // 5: almost-full holds off a new grant
        clear_log();
        tx_fifo_af = 1'b1;
        push_msg(1, 1, 8'h91);
        or_vec = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            or_vec |= s_grant;
        end
        chk("t5_no_grant", or_vec, 4'b0000);
        tx_fifo_af = 1'b0;
        step();
        step();
        chk("t5_grant", s_grant, 4'b0010); chk("t5_we", s_we, 1'b1);

        // 6: asynchronous reset in the middle of req2's message
        clear_log();
        push_msg(2, 5, 8'hE0);
        run_until_writes(2, 20);
        #2;
        reset_l = 1'b0;
        #1;
        chk("t6_grant", grant, 4'b0000); chk("t6_busy", busy, 1'b0);
        chk("t6_ready", req_ready, 4'b0000); chk("t6_we", tx_fifo_we, 1'b0);
        chk("t6_data", tx_fifo_wr_data, 8'h00); chk("t6_to", timeout_pulse, 1'b0);
        push_msg(0, 1, 8'h0F);
        step();
        reset_l = 1'b1;
        clear_log();
        run_until_writes(1, 10);
        if (log_gnt.size() == 1) chk("t6_req0_first", log_gnt[0], 4'b0001);

        // 7: randomized traffic, backpressure, almost-full and stalls
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rd_p[i] >= wr_p[i] && wr_p[i] < DEPTH - 8 && $urandom_range(0, 3) == 0)
                    push_msg(i, $urandom_range(1, 5), 8'($urandom));
                if (stall[i] == 0 && $urandom_range(0, 199) == 0)
                    stall[i] = $urandom_range(5, 30);
                en[i] = (stall[i] == 0) && ($urandom_range(0, 7) != 0);
                if (stall[i] > 0) stall[i]--;
            end
            tx_fifo_cf = ($urandom_range(0, 9) == 0);
            tx_fifo_af = ($urandom_range(0, 3) == 0);
            step();
        end
        chk("total_writes", dut_writes, m_pops);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
